// File: rtl/mdu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : mdu_pkg                                                           |
// | Brief  : Shared md_op encodings and FSM states for the multiply/divide unit |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
package mdu_pkg;

  localparam logic [2:0] MD_MULT  = 3'b000;
  localparam logic [2:0] MD_MULTU = 3'b001;
  localparam logic [2:0] MD_DIV   = 3'b010;
  localparam logic [2:0] MD_DIVU  = 3'b011;
  localparam logic [2:0] MD_MTHI  = 3'b100;
  localparam logic [2:0] MD_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } mdu_state_e;

endpackage
`default_nettype wire

// File: rtl/mdu_sign_adj.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : mdu_sign_adj                                                      |
// | Brief  : Conditional two's-complement negate (magnitude / sign restore)    |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module mdu_sign_adj #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_val,
  input  logic         i_neg,
  output logic [W-1:0] o_val
);

  assign o_val = i_neg ? (~i_val + W'(1)) : i_val;

endmodule
`default_nettype wire

// File: rtl/mul_div_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : mul_div_unit                                                      |
// | Brief  : Iterative mult/multu/div/divu unit holding architectural HI/LO    |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       md_op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] c_last = CW'(WIDTH - 1);

  mdu_state_e         r_state;
  mdu_state_e         w_next;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opnd;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;
  logic               r_is_div;
  logic               r_neg_hi;
  logic               r_neg_lo;
  logic               r_dz;

  logic               w_is_signed;
  logic               w_sa;
  logic               w_sb;
  logic [WIDTH-1:0]   w_rs_mag;
  logic [WIDTH-1:0]   w_rt_mag;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_step;
  logic [WIDTH:0]     w_div_t;
  logic               w_div_ge;
  logic [WIDTH-1:0]   w_div_diff;
  logic [2*WIDTH-1:0] w_div_step;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;

  assign w_is_signed = (md_op == MD_MULT) || (md_op == MD_DIV);
  assign w_sa        = w_is_signed & rs[WIDTH-1];
  assign w_sb        = w_is_signed & rt[WIDTH-1];

  mdu_sign_adj #(.W(WIDTH)) u_rs_mag (.i_val(rs), .i_neg(w_sa), .o_val(w_rs_mag));
  mdu_sign_adj #(.W(WIDTH)) u_rt_mag (.i_val(rt), .i_neg(w_sb), .o_val(w_rt_mag));

  mdu_sign_adj #(.W(2*WIDTH)) u_prod_fix (
    .i_val(r_acc), .i_neg(r_neg_lo), .o_val(w_prod_fix));
  mdu_sign_adj #(.W(WIDTH)) u_quo_fix (
    .i_val(r_acc[WIDTH-1:0]), .i_neg(r_neg_lo), .o_val(w_quo_fix));
  mdu_sign_adj #(.W(WIDTH)) u_rem_fix (
    .i_val(r_acc[2*WIDTH-1:WIDTH]), .i_neg(r_neg_hi), .o_val(w_rem_fix));

  // Multiply: upper half accumulates the multiplicand, multiplier drains out the bottom.
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_step = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Restoring divide: the trial difference always fits WIDTH bits when it is kept.
  assign w_div_t    = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_div_ge   = w_div_t >= {1'b0, r_opnd};
  assign w_div_diff = w_div_t[WIDTH-1:0] - r_opnd;
  assign w_div_step = w_div_ge ? {w_div_diff, r_acc[WIDTH-2:0], 1'b1}
                               : {r_acc[2*WIDTH-2:0], 1'b0};

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start && (md_op == MD_MULT || md_op == MD_MULTU)) w_next = ST_MUL;
        else if (start && (md_op == MD_DIV || md_op == MD_DIVU)) w_next = ST_DIV;
      end
      ST_MUL:  if (r_cnt == c_last) w_next = ST_FIX;
      ST_DIV:  if (r_cnt == c_last) w_next = ST_FIX;
      ST_FIX:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
      r_is_div <= 1'b0;
      r_neg_hi <= 1'b0;
      r_neg_lo <= 1'b0;
      r_dz     <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= (r_state == ST_FIX);
      case (r_state)
        ST_IDLE: if (start) begin
          case (md_op)
            MD_MULT, MD_MULTU: begin
              r_acc    <= {{WIDTH{1'b0}}, w_rt_mag};
              r_opnd   <= w_rs_mag;
              r_cnt    <= '0;
              r_is_div <= 1'b0;
              r_neg_hi <= w_sa ^ w_sb;
              r_neg_lo <= w_sa ^ w_sb;
              r_dz     <= 1'b0;
            end
            MD_DIV, MD_DIVU: begin
              r_acc    <= {{WIDTH{1'b0}}, w_rs_mag};
              r_opnd   <= w_rt_mag;
              r_cnt    <= '0;
              r_is_div <= 1'b1;
              r_neg_hi <= w_sa;
              r_neg_lo <= w_sa ^ w_sb;
              r_dz     <= (rt == '0);
            end
            MD_MTHI: r_hi <= rs;
            MD_MTLO: r_lo <= rs;
            default: ;
          endcase
        end
        ST_MUL: begin
          r_acc <= w_mul_step;
          r_cnt <= r_cnt + CW'(1);
        end
        ST_DIV: begin
          r_acc <= w_div_step;
          r_cnt <= r_cnt + CW'(1);
        end
        ST_FIX: begin
          if (r_is_div) begin
            // Divide by zero: the remainder path already reproduces rs; force the quotient.
            r_hi <= w_rem_fix;
            r_lo <= r_dz ? {WIDTH{1'b1}} : w_quo_fix;
          end else begin
            {r_hi, r_lo} <= w_prod_fix;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state != ST_IDLE);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_mul_div_unit                                                   |
// | Brief  : Directed self-checking bench for mul_div_unit                     |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_mul_div_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_asserts = 0;
  int n_fail    = 0;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .md_op(md_op),
    .rs(rs), .rt(rt), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    md_op = op;
    rs    = a;
    rt    = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts remaining busy cycles, then checks the done cycle and HI/LO.
  task automatic wait_result(input string tag, input int exp_cycles,
                             input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    check({tag, " busy/done while running"}, {62'd0, busy, done}, 64'b10);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check({tag, " busy cycles"}, 64'(n), 64'(exp_cycles));
    check({tag, " done pulse"}, {62'd0, busy, done}, 64'b01);
    check({tag, " hi"}, {32'd0, hi}, {32'd0, exp_hi});
    check({tag, " lo"}, {32'd0, lo}, {32'd0, exp_lo});
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    md_op = 3'b000;
    rs    = '0;
    rt    = '0;
    repeat (2) @(negedge clk);
    check("reset state", {30'd0, busy, done, hi}, 64'd0);
    check("reset lo", {32'd0, lo}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // multu max*max; HI/LO must hold their old value while busy
    issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu hold while busy", {hi, lo}, 64'd0);
    wait_result("multu max", 33, 32'hFFFF_FFFE, 32'h0000_0001);

    // Back-to-back issue in the done cycle of the previous op
    issue(3'b000, 32'hFFFF_FFFD, 32'd7);
    wait_result("mult -3*7", 33, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    issue(3'b000, 32'h8000_0000, 32'h8000_0000);
    wait_result("mult min*min", 33, 32'h4000_0000, 32'h0000_0000);

    issue(3'b010, 32'hFFFF_FFF9, 32'd2);
    wait_result("div -7/2", 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    issue(3'b011, 32'd100, 32'd7);
    wait_result("divu 100/7", 33, 32'd2, 32'd14);
    issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_result("div min/-1", 33, 32'd0, 32'h8000_0000);

    issue(3'b011, 32'd5, 32'd0);
    wait_result("divu 5/0", 33, 32'd5, 32'hFFFF_FFFF);
    issue(3'b010, 32'hFFFF_FFFB, 32'd0);
    wait_result("div -5/0", 33, 32'hFFFF_FFFB, 32'hFFFF_FFFF);

    // mthi then mtlo on consecutive cycles: single-cycle, no busy/done
    @(negedge clk);
    issue(3'b100, 32'h0000_1234, 32'd0);
    check("mthi hi", {32'd0, hi}, 64'h1234);
    check("mthi busy/done", {62'd0, busy, done}, 64'd0);
    issue(3'b101, 32'h0000_5678, 32'd0);
    check("mtlo hi/lo", {hi, lo}, 64'h0000_1234_0000_5678);
    check("mtlo busy/done", {62'd0, busy, done}, 64'd0);

    // Start while busy must be dropped
    issue(3'b000, 32'd2, 32'd3);
    issue(3'b000, 32'd5, 32'd5);
    wait_result("mult ignore-busy", 32, 32'd0, 32'd6);
    repeat (3) @(negedge clk);
    check("no queued op", {62'd0, busy, done}, 64'd0);
    check("result intact", {hi, lo}, 64'd6);

    // Async reset in the 10th MUL cycle
    issue(3'b001, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (9) @(negedge clk);
    check("busy before reset", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid-op reset ctrl", {62'd0, busy, done}, 64'd0);
    check("mid-op reset hi/lo", {hi, lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(3'b001, 32'd6, 32'd7);
    wait_result("multu 6*7 after reset", 33, 32'd0, 32'd42);
    @(negedge clk);
    check("done clears", {62'd0, busy, done}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
